// File: rtl/multi_zone_light_ctrl.sv
// Multi-zone lighting controller.
// Each zone runs an independent OFF/ON/HOLD/OVR occupancy FSM with a hold-off
// timer and a manual override. Only the daylight sensor is shared between zones.
// light_on is decoded from registered state; colour and lit-zone count are
// combinational from light_on.
module multi_zone_light_ctrl #(
    parameter int NUM_ZONES   = 4,
    parameter int COLOR_W     = 3,
    parameter int HOLD_CYCLES = 1000,
    localparam int TMR_W      = $clog2(HOLD_CYCLES + 1),
    localparam int CNT_W      = $clog2(NUM_ZONES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_ZONES-1:0]         motion,
    input  logic                         daylight,
    input  logic [NUM_ZONES*COLOR_W-1:0] color_select,
    input  logic [NUM_ZONES-1:0]         override_en,
    input  logic [NUM_ZONES-1:0]         override_val,
    output logic [NUM_ZONES-1:0]         light_on,
    output logic [NUM_ZONES*COLOR_W-1:0] light_color,
    output logic [CNT_W-1:0]             active_count
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2,
        ST_OVR  = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);

    state_t               state [NUM_ZONES];
    logic [TMR_W-1:0]     timer [NUM_ZONES];
    logic [NUM_ZONES-1:0] ovr_q;

    // Per-zone occupancy FSM; priority is override, then daylight, then motion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ZONES; i++) begin
                state[i] <= ST_OFF;
                timer[i] <= '0;
            end
            ovr_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_ZONES; i++) begin
                if (override_en[i]) begin
                    state[i] <= ST_OVR;
                    ovr_q[i] <= override_val[i];
                end else begin
                    case (state[i])
                        ST_OVR: begin
                            state[i] <= ST_OFF;
                        end
                        ST_OFF: begin
                            if (motion[i] && !daylight)
                                state[i] <= ST_ON;
                        end
                        ST_ON: begin
                            if (daylight) begin
                                state[i] <= ST_OFF;
                            end else if (!motion[i]) begin
                                state[i] <= ST_HOLD;
                                timer[i] <= HOLD_LOAD;
                            end
                        end
                        ST_HOLD: begin
                            if (daylight) begin
                                state[i] <= ST_OFF;
                            end else if (motion[i]) begin
                                state[i] <= ST_ON;
                            end else if (timer[i] == '0) begin
                                state[i] <= ST_OFF;
                            end else begin
                                timer[i] <= timer[i] - TMR_W'(1);
                            end
                        end
                        default: begin
                            state[i] <= ST_OFF;
                        end
                    endcase
                end
            end
        end
    end

    // Light decode from registered state.
    always_comb begin
        light_on = '0;
        for (int unsigned i = 0; i < NUM_ZONES; i++) begin
            light_on[i] = (state[i] == ST_ON) || (state[i] == ST_HOLD) ||
                          ((state[i] == ST_OVR) && ovr_q[i]);
        end
    end

    // Colour passes through only for lit zones.
    always_comb begin
        light_color = '0;
        for (int unsigned i = 0; i < NUM_ZONES; i++) begin
            if (light_on[i])
                light_color[i*COLOR_W +: COLOR_W] = color_select[i*COLOR_W +: COLOR_W];
        end
    end

    // Number of lit zones for the power monitor.
    always_comb begin
        active_count = '0;
        for (int unsigned i = 0; i < NUM_ZONES; i++) begin
            active_count = active_count + CNT_W'(light_on[i]);
        end
    end

endmodule

// File: tb/tb_multi_zone_light_ctrl.sv
// Directed self-checking bench for multi_zone_light_ctrl (4 zones, 3-bit colour, hold 8).
module tb_multi_zone_light_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  motion;
    logic        daylight;
    logic [11:0] color_select;
    logic [3:0]  override_en;
    logic [3:0]  override_val;
    logic [3:0]  light_on;
    logic [11:0] light_color;
    logic [2:0]  active_count;

    int n_cmp = 0;
    int n_err = 0;

    multi_zone_light_ctrl #(
        .NUM_ZONES  (4),
        .COLOR_W    (3),
        .HOLD_CYCLES(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .motion      (motion),
        .daylight    (daylight),
        .color_select(color_select),
        .override_en (override_en),
        .override_val(override_val),
        .light_on    (light_on),
        .light_color (light_color),
        .active_count(active_count)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; motion = '0; daylight = 1'b0;
        override_en = '0; override_val = '0; color_select = 12'hFFF;
        #12;
        n_cmp++;
        if (light_on !== 4'b0000) begin n_err++; $display("FAIL reset_on: got %b want 0000", light_on); end
        n_cmp++;
        if (light_color !== 12'h000) begin n_err++; $display("FAIL reset_color: got %h want 000", light_color); end
        n_cmp++;
        if (active_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", active_count); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        color_select = 12'b111_001_101_010;
        daylight = 1'b0; motion = 4'b0001;
        tick();
        n_cmp++;
        if (light_on !== 4'b0001) begin n_err++; $display("FAIL basic_first_edge: got %b want 0001", light_on); end
        n_cmp++;
        if (light_color !== 12'b000_000_000_010) begin n_err++; $display("FAIL basic_color: got %b want 000000000010", light_color); end
        n_cmp++;
        if (active_count !== 3'd1) begin n_err++; $display("FAIL basic_count: got %0d want 1", active_count); end
        tick(); tick();
        motion = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (light_on !== 4'b0001) begin n_err++; $display("FAIL basic_hold[%0d]: got %b want 0001", i, light_on); end
        end
        tick();
        n_cmp++;
        if (light_on !== 4'b0000) begin n_err++; $display("FAIL basic_hold_end: got %b want 0000", light_on); end
    endtask

    task automatic test_retrigger();
        motion = 4'b0001;
        tick();
        motion = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (light_on !== 4'b0001) begin n_err++; $display("FAIL retrig_pre[%0d]: got %b want 0001", i, light_on); end
        end
        motion = 4'b0001;
        tick();
        n_cmp++;
        if (light_on !== 4'b0001) begin n_err++; $display("FAIL retrig_on: got %b want 0001", light_on); end
        motion = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (light_on !== 4'b0001) begin n_err++; $display("FAIL retrig_hold[%0d]: got %b want 0001", i, light_on); end
        end
        tick();
        n_cmp++;
        if (light_on !== 4'b0000) begin n_err++; $display("FAIL retrig_end: got %b want 0000", light_on); end
    endtask

    task automatic test_daylight();
        daylight = 1'b0; motion = 4'b0101;
        tick();
        motion = 4'b0001;
        tick();
        n_cmp++;
        if (active_count !== 3'd2) begin n_err++; $display("FAIL day_count_before: got %0d want 2", active_count); end
        daylight = 1'b1;
        tick();
        n_cmp++;
        if (light_on !== 4'b0000) begin n_err++; $display("FAIL day_off: got %b want 0000", light_on); end
        n_cmp++;
        if (active_count !== 3'd0) begin n_err++; $display("FAIL day_count_after: got %0d want 0", active_count); end
        motion = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (light_on !== 4'b0000) begin n_err++; $display("FAIL day_block[%0d]: got %b want 0000", i, light_on); end
        end
    endtask

    task automatic test_override();
        motion = 4'b0000; daylight = 1'b1;
        color_select = 12'b011_110_001_100;
        override_en = 4'b0100; override_val = 4'b0100;
        tick();
        n_cmp++;
        if (light_on !== 4'b0100) begin n_err++; $display("FAIL ovr_on: got %b want 0100", light_on); end
        n_cmp++;
        if (light_color !== 12'b000_110_000_000) begin n_err++; $display("FAIL ovr_color: got %b want 000110000000", light_color); end
        n_cmp++;
        if (active_count !== 3'd1) begin n_err++; $display("FAIL ovr_count: got %0d want 1", active_count); end
        override_val = 4'b0000;
        tick();
        n_cmp++;
        if (light_on !== 4'b0000) begin n_err++; $display("FAIL ovr_val0: got %b want 0000", light_on); end
        override_val = 4'b0100;
        tick();
        n_cmp++;
        if (light_on !== 4'b0100) begin n_err++; $display("FAIL ovr_val1: got %b want 0100", light_on); end
        override_en = 4'b0000;
        tick();
        n_cmp++;
        if (light_on !== 4'b0000) begin n_err++; $display("FAIL ovr_release: got %b want 0000", light_on); end
        // Override beats motion; normal sensing resumes one cycle after release.
        daylight = 1'b0; motion = 4'b0100;
        override_en = 4'b0100; override_val = 4'b0000;
        tick();
        n_cmp++;
        if (light_on !== 4'b0000) begin n_err++; $display("FAIL ovr_prio: got %b want 0000", light_on); end
        override_en = 4'b0000;
        tick();
        n_cmp++;
        if (light_on !== 4'b0000) begin n_err++; $display("FAIL ovr_exit_off: got %b want 0000", light_on); end
        tick();
        n_cmp++;
        if (light_on !== 4'b0100) begin n_err++; $display("FAIL ovr_resume: got %b want 0100", light_on); end
    endtask

    task automatic test_color_count();
        daylight = 1'b0; override_en = '0; override_val = '0;
        motion = 4'b1111;
        color_select = 12'b111_001_101_010;
        tick();
        n_cmp++;
        if (light_on !== 4'b1111) begin n_err++; $display("FAIL cc_all_on: got %b want 1111", light_on); end
        n_cmp++;
        if (light_color !== 12'b111_001_101_010) begin n_err++; $display("FAIL cc_color: got %b want 111001101010", light_color); end
        n_cmp++;
        if (active_count !== 3'd4) begin n_err++; $display("FAIL cc_count4: got %0d want 4", active_count); end
        color_select = 12'b000_111_010_110;
        #1;
        n_cmp++;
        if (light_color !== 12'b000_111_010_110) begin n_err++; $display("FAIL cc_track: got %b want 000111010110", light_color); end
        color_select = 12'b111_001_101_010;
        override_en = 4'b0010; override_val = 4'b0000;
        tick();
        n_cmp++;
        if (light_on !== 4'b1101) begin n_err++; $display("FAIL cc_zone1_off: got %b want 1101", light_on); end
        n_cmp++;
        if (light_color !== 12'b111_001_000_010) begin n_err++; $display("FAIL cc_color3: got %b want 111001000010", light_color); end
        n_cmp++;
        if (active_count !== 3'd3) begin n_err++; $display("FAIL cc_count3: got %0d want 3", active_count); end
        override_en = '0; motion = '0;
    endtask

    task automatic test_async_reset();
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        daylight = 1'b0; motion = 4'b0001; color_select = 12'b111_001_101_010;
        tick();
        motion = 4'b0000;
        tick(); tick(); tick();
        n_cmp++;
        if (light_on !== 4'b0001) begin n_err++; $display("FAIL ar_in_hold: got %b want 0001", light_on); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (light_on !== 4'b0000) begin n_err++; $display("FAIL ar_async_on: got %b want 0000", light_on); end
        n_cmp++;
        if (light_color !== 12'h000) begin n_err++; $display("FAIL ar_async_color: got %h want 000", light_color); end
        n_cmp++;
        if (active_count !== 3'd0) begin n_err++; $display("FAIL ar_async_count: got %0d want 0", active_count); end
        tick();
        #2 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (light_on !== 4'b0000) begin n_err++; $display("FAIL ar_no_residual[%0d]: got %b want 0000", i, light_on); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_retrigger();
        test_daylight();
        test_override();
        test_color_count();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
